// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 peripheral with a one-entry TX holding buffer and an RX word strobe.
// All SPI pins are oversampled in the clk domain, so clk must run at least 4x SPI_clk.
module spi_slave #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] DUMMY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SPI_clk,
  input  logic             SPI_cs,
  input  logic             SPI_in,
  output logic             SPI_out,
  output logic             SPI_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nx;
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic [WIDTH-1:0] tx_buf, tx_shift, rx_shift, load_word;
  logic [CW-1:0] bit_cnt;
  logic full, word_done, accept, do_load;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign mosi_s    = mosi_q[1];
  assign accept    = tx_valid & ~full;
  assign load_word = full ? tx_buf : DUMMY;
  // A finished word reloads on the following sclk fall so words stream back-to-back.
  assign do_load   = ~cs_rise & (state == LOAD | (state == SHIFT & sclk_fall & word_done));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      state  <= IDLE;
    end else begin
      sclk_q <= {sclk_q[1:0], SPI_clk};
      cs_q   <= {cs_q[1:0], SPI_cs};
      mosi_q <= {mosi_q[0], SPI_in};
      state  <= state_nx;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cs_fall ? LOAD : IDLE;
      LOAD:    state_nx = cs_rise ? IDLE : SHIFT;
      default: state_nx = cs_rise ? IDLE : SHIFT;
    endcase
  end
  always_comb begin
    SPI_oe   = state != IDLE;
    tx_ready = ~full;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_buf      <= '0;
      full        <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      SPI_out     <= 1'b0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      full        <= accept | (full & ~do_load);
      if (accept) tx_buf <= tx_data;
      else if (do_load) tx_buf <= '0;
      if (state != IDLE && cs_rise) begin
        rx_shift  <= '0;
        tx_shift  <= '0;
        bit_cnt   <= '0;
        word_done <= 1'b0;
        SPI_out   <= 1'b0;
      end else if (do_load) begin
        tx_shift    <= load_word;
        SPI_out     <= load_word[WIDTH-1];
        tx_underrun <= ~full;
        bit_cnt     <= '0;
        word_done   <= 1'b0;
      end else if (state == SHIFT) begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
          bit_cnt  <= bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            rx_data   <= {rx_shift[WIDTH-2:0], mosi_s};
            rx_valid  <= 1'b1;
            word_done <= 1'b1;
          end
        end
        if (sclk_fall && !word_done) begin
          tx_shift <= tx_shift << 1;
          SPI_out  <= tx_shift[WIDTH-2];
        end
      end
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Peripheral-side (slave) end of the SPI link driven by the SPI register file: receives words on MOSI and returns words on MISO.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, fixed word length.
- Samples SPI_clk, SPI_cs and SPI_in in the system clk domain, so no second clock domain is needed.
- Parallel side faces a device model or register bank: one-entry TX holding buffer with valid/ready handshake; RX word output with single-cycle valid pulse.

Parameters:
WIDTH, 32, bits per SPI word (matches `W_CPU)
DUMMY, 32'h0000_0000, word shifted out when no TX word is buffered at load time

Ports:
clk  input  1  system clock; must run at >= 4x SPI_clk
rst  input  1  asynchronous, active-high reset
SPI_clk  input  1  serial clock from master
SPI_cs  input  1  chip select from master, active low
SPI_in  input  1  MOSI serial data from master
SPI_out  output  1  MISO serial data to master
SPI_oe  output  1  MISO drive enable; 1 while selected
tx_data  input  WIDTH  next word to return to master
tx_valid  input  1  tx_data offered
tx_ready  output  1  TX buffer empty; word accepted when tx_valid && tx_ready
rx_data  output  WIDTH  last complete word received
rx_valid  output  1  one-clk pulse when rx_data updates
tx_underrun  output  1  one-clk pulse when DUMMY is loaded instead of a buffered word

Behaviour:
- Reset values (async, immediate on rst rising): all shift registers, rx_data and tx buffer = 0; bit counter = 0; state IDLE; SPI_out = 0; SPI_oe = 0; rx_valid = 0; tx_underrun = 0; tx_ready = 1.
- Synchronisers:
  - 2-FF synchroniser on each of SPI_clk, SPI_cs and SPI_in, plus one further stage on SPI_clk and SPI_cs for edge detection.
  - sclk_rise / sclk_fall / cs_fall / cs_rise are single-clk pulses, 3 clk after the pin edge.
- States:
  - IDLE: SPI_oe = 0, SPI_out = 0. cs_fall -> LOAD.
  - LOAD (1 clk): tx_shift <= buffered word, clearing the buffer; if the buffer is empty, load DUMMY and pulse tx_underrun. bit_cnt <= 0; SPI_out <= MSB of the loaded word; SPI_oe <= 1; -> SHIFT.
  - SHIFT:
    - On sclk_rise: rx_shift <= {rx_shift[WIDTH-2:0], mosi_s}; bit_cnt++.
    - When bit_cnt == WIDTH-1 on sclk_rise: rx_data <= {rx_shift[WIDTH-2:0], mosi_s}; rx_valid pulses next clk; bit_cnt <= 0; set word_done.
    - On sclk_fall with word_done clear: tx_shift <<= 1; SPI_out <= new MSB.
    - On sclk_fall with word_done set: clear word_done and perform the LOAD action in-place (back-to-back words, no idle bit).
    - cs_rise -> IDLE.
- Abort: cs_rise mid-word discards the partial rx_shift (no rx_valid) and the current tx_shift contents. The tx buffer is untouched. bit_cnt <= 0.
- TX buffer:
  - Single entry; tx_ready = ~full (registered full flag).
  - Accept and load in the same clk: the load takes the old contents, or DUMMY if empty. The accepted word is stored for the next load; there is no bypass.
- No RX backpressure: a new word overwrites rx_data; consumers must take it on the rx_valid pulse.
- sclk edges while SPI_cs is deasserted are ignored. A cs_fall in LOAD/SHIFT is impossible without an intervening cs_rise.

Test Plan:
- Single word: preload tx_data=32'hA5A5_0F0F; master sends 32'h1234_5678 -> rx_valid pulses once, rx_data=32'h1234_5678, MISO stream = A5A50F0F MSB first, tx_ready returns to 1 after LOAD.
- Underrun: no TX word; master sends 32'hFFFF_FFFF -> MISO all 0 (DUMMY), tx_underrun pulses once at LOAD, rx_data=32'hFFFF_FFFF.
- Back-to-back: buffer 32'h1111_1111; hold cs low; master sends 2 words; buffer 32'h2222_2222 during word 1 -> MISO = 11111111 then 22222222, two rx_valid pulses with the correct words.
- Abort: cs raised after 13 bits -> no rx_valid, SPI_oe=0 within 4 clk. The next full transaction receives 32'hCAFE_BABE correctly from bit 0.
- Async reset mid-word (bit 20) -> all outputs at reset values in the same timestep; the following transaction is clean.
- Handshake: tx_valid held with the buffer full -> tx_ready=0, data not accepted. It is accepted the clk after LOAD frees the buffer.
